// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - two-requester arbiter for the single-port data memory with fixed access latency.
// Optional: define DM_P0_PRIORITY_EN for fixed port-0 priority instead of round-robin.
module dm_port_arbiter #(
    parameter int AW  = 7,
    parameter int DW  = 32,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_done,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_done,
    output logic [DW-1:0] p1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t        state;
    logic          owner;
    logic [3:0]    cnt;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;
    logic          pick_p1;

`ifndef DM_P0_PRIORITY_EN
    logic          rr_last;
`endif

    always_comb begin
`ifdef DM_P0_PRIORITY_EN
        pick_p1 = ~p0_req;
`else
        pick_p1 = (p0_req && p1_req) ? ~rr_last : ~p0_req;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            cnt       <= '0;
            p0_gnt    <= 1'b0;
            p1_gnt    <= 1'b0;
            p0_done   <= 1'b0;
            p1_done   <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifndef DM_P0_PRIORITY_EN
            rr_last   <= 1'b1;
`endif
        end else begin
            p0_gnt  <= 1'b0;
            p1_gnt  <= 1'b0;
            p0_done <= 1'b0;
            p1_done <= 1'b0;
            mem_en  <= 1'b0;
            case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        // mem_we/addr/wdata double as the latched request; they hold until the next grant
                        owner     <= pick_p1;
                        mem_we    <= pick_p1 ? p1_we    : p0_we;
                        mem_addr  <= pick_p1 ? p1_addr  : p0_addr;
                        mem_wdata <= pick_p1 ? p1_wdata : p0_wdata;
                        mem_en    <= 1'b1;
                        p0_gnt    <= ~pick_p1;
                        p1_gnt    <= pick_p1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    cnt   <= CNT_INIT;
                    state <= WAIT;
`ifndef DM_P0_PRIORITY_EN
                    rr_last <= owner;
`endif
                    if (LAT == 1) begin
                        p0_done <= ~owner;
                        p1_done <= owner;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        if (!mem_we) begin
                            if (owner) rdata1_q <= mem_rdata;
                            else       rdata0_q <= mem_rdata;
                        end
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                        // done is registered one edge early so it lines up with the counter reaching 0
                        if (cnt == 4'd1) begin
                            p0_done <= ~owner;
                            p1_done <= owner;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory data is valid during the done cycle; the register takes over from the next cycle
    assign p0_rdata = (p0_done && !mem_we) ? mem_rdata : rdata0_q;
    assign p1_rdata = (p1_done && !mem_we) ? mem_rdata : rdata1_q;
    assign stall    = p0_req & ~p0_done;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb/tb_dm_port_arbiter.sv - directed self-checking bench for dm_port_arbiter (LAT=2 and LAT=1 instances).
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;

    logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [6:0]  p0_addr = 0, p1_addr = 0;
    logic [31:0] p0_wdata = 0, p1_wdata = 0;
    logic        p0_gnt, p0_done, p1_gnt, p1_done, mem_en, mem_we, stall;
    logic [31:0] p0_rdata, p1_rdata, mem_wdata, mem_rdata;
    logic [6:0]  mem_addr;

    logic        b_p0_req = 0;
    logic [6:0]  b_p0_addr = 0;
    logic        b_p0_gnt, b_p0_done, b_p1_gnt, b_p1_done, b_mem_en, b_mem_we, b_stall;
    logic [31:0] b_p0_rdata, b_p1_rdata, b_mem_wdata;
    logic [31:0] b_mem_rdata = 0;
    logic [6:0]  b_mem_addr;

    always #5 clk = ~clk;

    dm_port_arbiter #(.AW(7), .DW(32), .LAT(2)) u_dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall)
    );

    dm_port_arbiter #(.AW(7), .DW(32), .LAT(1)) u_dut_lat1 (
        .clk(clk), .rst(rst),
        .p0_req(b_p0_req), .p0_we(1'b0), .p0_addr(b_p0_addr), .p0_wdata(32'd0),
        .p0_gnt(b_p0_gnt), .p0_done(b_p0_done), .p0_rdata(b_p0_rdata),
        .p1_req(1'b0), .p1_we(1'b0), .p1_addr(7'd0), .p1_wdata(32'd0),
        .p1_gnt(b_p1_gnt), .p1_done(b_p1_done), .p1_rdata(b_p1_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .stall(b_stall)
    );

    // Two-cycle memory for the LAT=2 instance
    logic [31:0] mem_a [0:127];
    logic [31:0] pipe_a0, pipe_a1;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_a[mem_addr] <= mem_wdata;
            else        pipe_a0 <= mem_a[mem_addr];
        end
        pipe_a1 <= pipe_a0;
    end
    assign mem_rdata = pipe_a1;

    // One-cycle ROM for the LAT=1 instance: word n reads as A5A5_00nn
    always @(posedge clk) begin
        if (b_mem_en) b_mem_rdata <= 32'hA5A5_0000 | {25'd0, b_mem_addr};
    end

    task automatic run_a(input logic port, input logic we, input logic [6:0] addr,
                         input logic [31:0] wdata, output int gnt_c, output int done_c,
                         output logic [31:0] rd, output logic men, output logic mwe,
                         output logic [6:0] maddr, output logic [31:0] mwdata,
                         output logic [7:0] stall_v);
        gnt_c = -1; done_c = -1; rd = '0; men = 0; mwe = 0; maddr = '0; mwdata = '0; stall_v = '0;
        @(posedge clk); #1;
        if (port) begin p1_req = 1; p1_we = we; p1_addr = addr; p1_wdata = wdata; end
        else      begin p0_req = 1; p0_we = we; p0_addr = addr; p0_wdata = wdata; end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c < 8) stall_v[c] = stall;
            if (gnt_c < 0 && (port ? p1_gnt : p0_gnt)) begin
                gnt_c = c; men = mem_en; mwe = mem_we; maddr = mem_addr; mwdata = mem_wdata;
            end
            if (port ? p1_done : p0_done) begin
                done_c = c; rd = port ? p1_rdata : p0_rdata;
                break;
            end
        end
        if (port) p1_req = 0; else p0_req = 0;
    endtask

    task automatic test_reset;
        #2;
        n_tests++;
        if ({p0_gnt, p1_gnt, p0_done, p1_done, mem_en, mem_we, stall} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000000", {p0_gnt, p1_gnt, p0_done, p1_done, mem_en, mem_we, stall});
        end
        n_tests++;
        if ({p0_rdata, p1_rdata, mem_wdata, mem_addr} !== 103'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h/%h/%h expected 0", p0_rdata, p1_rdata, mem_wdata, mem_addr);
        end
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    task automatic test_store;
        int g, d; logic [31:0] rd, mwd; logic men, mwe; logic [6:0] ma; logic [7:0] sv;
        run_a(1, 1, 7'd7, 32'h1234_5678, g, d, rd, men, mwe, ma, mwd, sv);
        n_tests++;
        if (g !== 1) begin n_fail++; $display("FAIL store_gnt_cycle: got %0d expected 1", g); end
        n_tests++;
        if ({men, mwe, ma, mwd} !== {1'b1, 1'b1, 7'd7, 32'h1234_5678}) begin
            n_fail++; $display("FAIL store_mem_bus: got en=%b we=%b addr=%0d wdata=%h expected 1 1 7 12345678", men, mwe, ma, mwd);
        end
        n_tests++;
        if (d !== 3) begin n_fail++; $display("FAIL store_done_cycle: got %0d expected 3", d); end
        n_tests++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL store_rdata_unchanged: got %h expected 00000000", rd); end
        n_tests++;
        if (sv !== 8'h00) begin n_fail++; $display("FAIL store_no_stall: got %b expected 00000000", sv); end
        run_a(1, 1, 7'd5, 32'hDEAD_BEEF, g, d, rd, men, mwe, ma, mwd, sv);
        n_tests++;
        if (d !== 3) begin n_fail++; $display("FAIL store2_done_cycle: got %0d expected 3", d); end
    endtask

    task automatic test_load;
        int g, d; logic [31:0] rd, mwd; logic men, mwe; logic [6:0] ma; logic [7:0] sv;
        run_a(0, 0, 7'd5, 32'h0, g, d, rd, men, mwe, ma, mwd, sv);
        n_tests++;
        if ({g, d} !== {32'd1, 32'd3}) begin n_fail++; $display("FAIL load_timing: got gnt=%0d done=%0d expected 1 3", g, d); end
        n_tests++;
        if ({men, mwe, ma} !== {1'b1, 1'b0, 7'd5}) begin
            n_fail++; $display("FAIL load_mem_bus: got en=%b we=%b addr=%0d expected 1 0 5", men, mwe, ma);
        end
        n_tests++;
        if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_rdata: got %h expected deadbeef", rd); end
        n_tests++;
        if (sv !== 8'b0000_0111) begin n_fail++; $display("FAIL load_stall: got %b expected 00000111", sv); end
        @(negedge clk);
        n_tests++;
        if ({p0_rdata, p0_done, mem_en, mem_addr} !== {32'hDEAD_BEEF, 1'b0, 1'b0, 7'd5}) begin
            n_fail++; $display("FAIL load_hold: got rdata=%h done=%b en=%b addr=%0d expected deadbeef 0 0 5", p0_rdata, p0_done, mem_en, mem_addr);
        end
    endtask

    task automatic test_contention;
        int g0 [2]; int n0 = 0; int g1 = -1; int rer_at = -1; logic reraised = 0;
        int e0 [2]; int e1;
        g0[0] = -1; g0[1] = -1;
`ifdef DM_P0_PRIORITY_EN
        e0[0] = 1; e0[1] = 5; e1 = 9;
`else
        e0[0] = 1; e0[1] = 9; e1 = 5;
`endif
        @(negedge clk); rst = 0;
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        p0_req = 1; p0_we = 0; p0_addr = 7'd5;
        p1_req = 1; p1_we = 0; p1_addr = 7'd7;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (p0_gnt) begin if (n0 < 2) g0[n0] = c; n0++; end
            if (p1_gnt) g1 = c;
            if (p1_done) p1_req = 0;
            if (p0_done) begin
                p0_req = 0;
                if (!reraised) rer_at = c + 1;
            end else if (c == rer_at) begin
                p0_req = 1; reraised = 1;
            end
        end
        p0_req = 0; p1_req = 0;
        n_tests++;
        if (g0[0] !== e0[0]) begin n_fail++; $display("FAIL contention_first_p0: got %0d expected %0d", g0[0], e0[0]); end
        n_tests++;
        if (g1 !== e1) begin n_fail++; $display("FAIL contention_p1_gnt: got %0d expected %0d", g1, e1); end
        n_tests++;
        if (g0[1] !== e0[1]) begin n_fail++; $display("FAIL contention_second_p0: got %0d expected %0d", g0[1], e0[1]); end
        n_tests++;
        if (p1_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL contention_p1_rdata: got %h expected 12345678", p1_rdata); end
    endtask

    task automatic test_back_to_back;
        int d [2]; logic [31:0] r [2]; int n = 0;
        d[0] = -1; d[1] = -1; r[0] = '0; r[1] = '0;
        @(posedge clk); #1;
        b_p0_req = 1; b_p0_addr = 7'd1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (b_p0_done) begin
                d[n] = c; r[n] = b_p0_rdata; n++;
                if (n == 1) b_p0_addr = 7'd2;
                else break;
            end
        end
        b_p0_req = 0;
        n_tests++;
        if ({d[0], d[1]} !== {32'd2, 32'd5}) begin n_fail++; $display("FAIL b2b_done_cycles: got %0d,%0d expected 2,5", d[0], d[1]); end
        n_tests++;
        if (r[0] !== 32'hA5A5_0001) begin n_fail++; $display("FAIL b2b_rdata1: got %h expected a5a50001", r[0]); end
        n_tests++;
        if (r[1] !== 32'hA5A5_0002) begin n_fail++; $display("FAIL b2b_rdata2: got %h expected a5a50002", r[1]); end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        @(posedge clk); #1;
        p0_req = 1; p0_we = 0; p0_addr = 7'd5;
        repeat (3) @(negedge clk);
        rst = 0; #1;
        n_tests++;
        if ({p0_gnt, p0_done, mem_en, mem_we, stall} !== 5'b00001) begin
            n_fail++; $display("FAIL midrst_ctrl: got %b expected 00001", {p0_gnt, p0_done, mem_en, mem_we, stall});
        end
        n_tests++;
        if ({p0_rdata, p1_rdata, mem_wdata, mem_addr} !== 103'd0) begin
            n_fail++; $display("FAIL midrst_data: got %h/%h/%h/%h expected 0", p0_rdata, p1_rdata, mem_wdata, mem_addr);
        end
        p0_req = 0; #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL midrst_stall_drop: got %b expected 0", stall); end
        @(negedge clk); rst = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (p0_done || p0_gnt) seen++;
        end
        n_tests++;
        if (seen !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d events expected 0", seen); end
    endtask

    task automatic test_req_held;
        int g [2]; int d [2]; int ng = 0; int nd = 0; logic [6:0] a2 = '1; logic [31:0] r2 = '0;
        g[0] = -1; g[1] = -1; d[0] = -1; d[1] = -1;
        @(posedge clk); #1;
        p0_req = 1; p0_we = 0; p0_addr = 7'd5;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (p0_gnt && ng < 2) begin g[ng] = c; if (ng == 1) a2 = mem_addr; ng++; end
            if (p0_done && nd < 2) begin d[nd] = c; if (nd == 1) r2 = p0_rdata; nd++; end
            if (nd == 2) break;
        end
        p0_req = 0;
        n_tests++;
        if ({g[0], g[1]} !== {32'd1, 32'd5}) begin n_fail++; $display("FAIL held_gnt_cycles: got %0d,%0d expected 1,5", g[0], g[1]); end
        n_tests++;
        if ({d[0], d[1]} !== {32'd3, 32'd7}) begin n_fail++; $display("FAIL held_done_cycles: got %0d,%0d expected 3,7", d[0], d[1]); end
        n_tests++;
        if ({a2, r2} !== {7'd5, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL held_second_access: got addr=%0d rdata=%h expected 5 deadbeef", a2, r2); end
    endtask

    initial begin
        test_reset;
        test_store;
        test_load;
        test_contention;
        test_back_to_back;
        test_reset_mid;
        test_req_held;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Arbitrates the single-port data memory (128 x 32-bit) between two requesters.
  - Port 0: the pipeline memory stage (loads/stores).
  - Port 1: the external loader/debug path.
- Sequences each access through a fixed memory latency.
- Returns read data with a one-cycle done pulse.
- Raises a pipeline stall while a port-0 access is pending.

Parameters:
- AW, 7, word-address width (128 words)
- DW, 32, data width
- LAT, 2, cycles from mem_en to data valid/write complete; legal 1..15

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- p0_req  in  1  port-0 access request, held until p0_done
- p0_we  in  1  port-0 write enable (1=store, 0=load)
- p0_addr  in  AW  port-0 word address
- p0_wdata  in  DW  port-0 store data
- p0_gnt  out  1  one-cycle pulse: port 0 owns memory
- p0_done  out  1  one-cycle pulse: port-0 access complete
- p0_rdata  out  DW  port-0 load data, valid when p0_done=1, held after
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_done, p1_rdata: same as port 0, for port 1
- mem_en  out  1  memory enable, one-cycle pulse per access
- mem_we  out  1  memory write strobe, qualified by mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid LAT cycles after mem_en
- stall  out  1  pipeline stall = p0_req & ~p0_done (combinational)

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All registered outputs are 0, including gnt, done, rdata, mem_*.
  - Latency counter is 0; rr_last=1, so port 0 wins the first contention.
- FSM states: IDLE, ACCESS, WAIT.
- IDLE:
  - On an edge with any req=1, select the owner.
    - Single requester: that requester wins.
    - Both requesting: the port not equal to rr_last wins.
  - Latch owner, we, addr and wdata from the owner's inputs.
  - Move to ACCESS; the owner's gnt=1 for that cycle.
- ACCESS (exactly 1 cycle):
  - mem_en=1; mem_we/addr/wdata driven from the latched values.
  - Load counter with LAT-1, go to WAIT.
  - rr_last <= owner.
- WAIT:
  - Decrement the counter each edge.
  - When the counter is 0: capture mem_rdata into the owner's rdata (loads only; rdata unchanged on stores), pulse the owner's done, return to IDLE.
  - LAT=1: WAIT lasts one cycle.
- Latency:
  - req sampled at edge k; gnt/mem_en high during cycle k+1.
  - done high during cycle k+1+LAT.
  - Minimum turnaround between accesses = LAT+2 cycles.
- Handshake:
  - The requester holds req/we/addr/wdata stable until done.
  - The requester deasserts req in the done cycle; req still high at the next IDLE edge is a new request.
  - The inputs of the non-owning port are ignored while busy.
- Memory outputs: mem_we/mem_addr/mem_wdata hold their values outside ACCESS; mem_en is 0 outside ACCESS.
- Simultaneous req in IDLE: round-robin as above; the loser stays pending and is granted next IDLE.
- Reset mid-access: the access is abandoned and no done is issued; a write already strobed in ACCESS is not undone.
- stall has no registered delay; it falls in the p0_done cycle.

Optional Feature:
- DM_P0_PRIORITY_EN
  - Defined: fixed priority; port 0 always wins contention and rr_last is unused. Port 1 can starve while port 0 requests back-to-back.
  - Undefined: round-robin as specified.

Test Plan:
- LAT=2, p0 load addr 5, memory word 5 = 32'hDEADBEEF, req at edge 0:
  - mem_en in cycle 1; p0_done and p0_rdata=DEADBEEF in cycle 3.
  - stall=1 in cycles 0-2, 0 in cycle 3.
- p1 store addr 7, data 32'h12345678:
  - mem_en=1, mem_we=1, mem_addr=7, mem_wdata=12345678 in the ACCESS cycle.
  - p1_done 2 cycles later; p1_rdata unchanged.
- p0 and p1 request in the same cycle after reset:
  - p0 granted first, p1 granted at the next IDLE.
  - Both again together: p0 is rr_last, so p1 wins. With DM_P0_PRIORITY_EN defined, p0 wins both times.
- LAT=1 back-to-back p0 loads of addr 1 then 2: done pulses 3 cycles apart, correct rdata each time.
- rst driven low in the WAIT cycle of a p0 load, then released:
  - All outputs 0 immediately, with no clock edge required.
  - No p0_done; stall falls only when p0_req drops.
- p0 holds req high through the done cycle: a second access to the same address starts at the following IDLE edge (documented requester error behaviour).
